// File: rtl/pp_select_accumulate_if.sv
// pp_select_accumulate_if: operand, multiple-generator and product bus of the partial-product stage
interface pp_select_accumulate_if #(parameter int N_DIG = 4);
    localparam int W = 4 * N_DIG;
    localparam int MW = W + 4;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    x_bcd;
    logic [W-1:0]    y_bcd;
    logic [W-1:0]    x_bcd_o;
    logic [MW-1:0]   x1_4221;
    logic [MW-1:0]   x2_4221;
    logic [MW-1:0]   x3_4221;
    logic [MW-1:0]   x4_4221;
    logic [MW-1:0]   x5_4221;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  product_bcd;
    logic            bcd_err;
    modport master (
        output in_valid, x_bcd, y_bcd, x1_4221, x2_4221, x3_4221, x4_4221, x5_4221, out_ready,
        input  in_ready, x_bcd_o, out_valid, product_bcd, bcd_err
    );
    modport slave (
        input  in_valid, x_bcd, y_bcd, x1_4221, x2_4221, x3_4221, x4_4221, x5_4221, out_ready,
        output in_ready, x_bcd_o, out_valid, product_bcd, bcd_err
    );
endinterface

// File: rtl/pp_select_accumulate.sv
// pp_select_accumulate: digit-serial BCD partial-product select and accumulate stage
module pp_select_accumulate #(
    parameter int N_DIG = 4
) (
    input  logic clk,
    input  logic rst_n,
    pp_select_accumulate_if.slave bus
);
    localparam int W = 4 * N_DIG;
    localparam int MW = W + 4;
    localparam int CW = N_DIG > 1 ? $clog2(N_DIG) : 1;
    typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;
    state_t state, state_nx;
    logic [W-1:0] x_reg, y_reg, acc_hi, prod_lo;
    logic [MW-1:0] m1, m2, m3, m4, m5, ma, mb, s;
    logic [CW-1:0] cnt;
    logic [2*W-1:0] prod_q;
    logic err_q, ov_q, bad, ge5, last;
    logic [3:0] d, de, b;
    function automatic logic [MW-1:0] to_8421(input logic [MW-1:0] v);
        logic [MW-1:0] r;
        r = '0;
        for (int i = 0; i <= N_DIG; i++)
            r[4*i+:4] = {1'b0, v[4*i+3], 2'b00} + {2'b00, v[4*i+2], 1'b0}
                      + {2'b00, v[4*i+1], 1'b0} + {3'b000, v[4*i]};
        return r;
    endfunction
    // Final decimal carry is dropped: operands never overflow N_DIG+1 digits.
    function automatic logic [MW-1:0] bcd_add(input logic [MW-1:0] a, input logic [MW-1:0] c);
        logic [MW-1:0] r;
        logic [4:0] t;
        logic cy;
        r = '0;
        cy = 1'b0;
        for (int i = 0; i <= N_DIG; i++) begin
            t = {1'b0, a[4*i+:4]} + {1'b0, c[4*i+:4]} + {4'b0000, cy};
            cy = t > 5'd9;
            r[4*i+:4] = cy ? t[3:0] + 4'd6 : t[3:0];
        end
        return r;
    endfunction
    // Digit d recoded as a + b with a in {0,5}, b in {0..4}; invalid digits act as 0.
    always_comb begin
        d = y_reg[4*cnt+:4];
        bad = d > 4'd9;
        de = bad ? 4'd0 : d;
        ge5 = de >= 4'd5;
        b = ge5 ? de - 4'd5 : de;
        ma = ge5 ? m5 : '0;
        mb = b == 4'd1 ? m1 : b == 4'd2 ? m2 : b == 4'd3 ? m3 : b == 4'd4 ? m4 : '0;
        s = bcd_add({4'd0, acc_hi}, bcd_add(ma, mb));
        last = cnt == CW'(N_DIG - 1);
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.in_valid ? LOAD : IDLE;
            LOAD:    state_nx = ITER;
            ITER:    state_nx = last ? DONE : ITER;
            default: state_nx = bus.out_ready ? IDLE : DONE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            x_reg <= '0;
            y_reg <= '0;
            m1 <= '0;
            m2 <= '0;
            m3 <= '0;
            m4 <= '0;
            m5 <= '0;
            acc_hi <= '0;
            prod_lo <= '0;
            cnt <= '0;
            prod_q <= '0;
            err_q <= 1'b0;
            ov_q <= 1'b0;
        end else begin
            state <= state_nx;
            ov_q <= state_nx == DONE;
            case (state)
                IDLE: if (bus.in_valid) begin
                    x_reg <= bus.x_bcd;
                    y_reg <= bus.y_bcd;
                    acc_hi <= '0;
                    prod_lo <= '0;
                    err_q <= 1'b0;
                end
                LOAD: begin
                    m1 <= to_8421(bus.x1_4221);
                    m2 <= to_8421(bus.x2_4221);
                    m3 <= to_8421(bus.x3_4221);
                    m4 <= to_8421(bus.x4_4221);
                    m5 <= to_8421(bus.x5_4221);
                    cnt <= '0;
                end
                ITER: begin
                    acc_hi <= s[MW-1:4];
                    prod_lo <= {s[3:0], prod_lo[W-1:4]};
                    err_q <= err_q | bad;
                    cnt <= cnt + 1'b1;
                    if (last) prod_q <= {s, prod_lo[W-1:4]};
                end
                default: ;
            endcase
        end
    end
    assign bus.in_ready = state == IDLE;
    assign bus.out_valid = ov_q;
    assign bus.product_bcd = prod_q;
    assign bus.bcd_err = err_q;
    assign bus.x_bcd_o = x_reg;
endmodule
